// File: rtl/rom_program_loader_if.sv
// Purpose: bundles the loader's control, byte-stream and ROM-programming signals.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready handshake on the byte stream; ROM side is strobe-only.
interface rom_program_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   length;
    logic              abort;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              edit;
    logic [ADDR_W-1:0] unit;
    logic [DATA_W-1:0] code;
    logic              send;
    logic              busy;
    logic              done;
    logic [1:0]        err;
    logic [ADDR_W:0]   count;

    // Requester / byte source / ROM observer side
    modport master (
        output start, base, length, abort, in_valid, in_data,
        input  in_ready, edit, unit, code, send, busy, done, err, count
    );

    // Loader side
    modport slave (
        input  start, base, length, abort, in_valid, in_data,
        output in_ready, edit, unit, code, send, busy, done, err, count
    );
endinterface

// File: rtl/rom_program_loader.sv
// Purpose: streams program bytes into ROM unit by unit, then verifies a trailing checksum byte.
// Latency: start to done = 2*length + 2 cycles when the source never stalls; bad length finishes in 1.
// Backpressure: in_ready only in RECV/CSUM, so at most one byte per two cycles; in_valid low stalls freely.
module rom_program_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    rom_program_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CSUM  = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_CSUM  = 2'b01;
    localparam logic [1:0] ERR_LEN   = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   length_q, length_d;
    logic [ADDR_W-1:0] unit_q, unit_d;
    logic [DATA_W-1:0] code_q, code_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [1:0]        err_q, err_d;

    logic              in_ready;
    logic              len_ok;

    // Handshake acceptance and ROM strobes are pure state decodes, so reset drops them at once
    assign in_ready     = (state_q == RECV) || (state_q == CSUM);
    assign len_ok       = (bus.length != '0) && (bus.length <= LEN_MAX);

    assign bus.in_ready = in_ready;
    assign bus.edit     = (state_q == RECV) || (state_q == WRITE) || (state_q == CSUM);
    assign bus.send     = (state_q == WRITE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == FIN);
    assign bus.unit     = unit_q;
    assign bus.code     = code_q;
    assign bus.err      = err_q;
    assign bus.count    = count_q;

    // Next-state and datapath: abort outranks a pending transfer; a WRITE-cycle abort still counts its send
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        length_d = length_q;
        unit_d   = unit_q;
        code_d   = code_q;
        count_d  = count_q;
        sum_d    = sum_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    count_d = '0;
                    sum_d   = '0;
                    if (len_ok) begin
                        base_d   = bus.base;
                        length_d = bus.length;
                        err_d    = ERR_OK;
                        state_d  = RECV;
                    end else begin
                        err_d    = ERR_LEN;
                        state_d  = FIN;
                    end
                end
            end

            RECV: begin
                if (bus.abort) begin
                    err_d   = ERR_ABORT;
                    state_d = FIN;
                end else if (bus.in_valid) begin
                    code_d  = bus.in_data;
                    unit_d  = base_q + count_q[ADDR_W-1:0];
                    sum_d   = sum_q + bus.in_data;
                    state_d = WRITE;
                end
            end

            WRITE: begin
                count_d = count_q + CNT_ONE;
                if (bus.abort) begin
                    err_d   = ERR_ABORT;
                    state_d = FIN;
                end else if (count_d == length_q) begin
                    state_d = CSUM;
                end else begin
                    state_d = RECV;
                end
            end

            CSUM: begin
                if (bus.abort) begin
                    err_d   = ERR_ABORT;
                    state_d = FIN;
                end else if (bus.in_valid) begin
                    err_d   = (bus.in_data == sum_q) ? ERR_OK : ERR_CSUM;
                    state_d = FIN;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            length_q <= '0;
            unit_q   <= '0;
            code_q   <= '0;
            count_q  <= '0;
            sum_q    <= '0;
            err_q    <= ERR_OK;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            length_q <= length_d;
            unit_q   <= unit_d;
            code_q   <= code_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            err_q    <= err_d;
        end
    end

endmodule
